// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared defaults and types for the register file slice.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default entry and address widths
//   DEPTH                                   : entry count at the default address width
//   data_t / addr_t                         : default-width data and address types
//   clear_state_e                           : bulk-clear sequencer states
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_e;

endpackage

// File: rtl/register_file_read_port.sv
// register_file_read_port
//   One registered read port with write-first bypass.
//   clock     : clock, rising edge
//   rf_reset  : asynchronous active-high reset, loads RESET_VALUE
//   word      : storage word currently addressed by rd_addr
//   rd_addr   : read address
//   wr_en     : effective write enable for this edge (external or clear engine)
//   wr_addr   : effective write address
//   wr_data   : effective write data
//   rd_data   : registered read data
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  rf_reset,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] next_data;

  // A write landing on the same edge wins over the stored word.
  always_comb begin
    next_data = word;
    if (wr_en && (wr_addr == rd_addr)) begin
      next_data = wr_data;
    end
  end

  always_ff @(posedge clock or posedge rf_reset) begin
    if (rf_reset) begin
      rd_data <= RESET_VALUE;
    end else begin
      rd_data <= next_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file
//   DEPTH-entry register file, one write port, two registered read ports with
//   write-first bypass, and a sequenced bulk-clear engine.
//   Optional build macro RF_ZERO_REG_EN: entry 0 hardwired to RESET_VALUE.
//   clock        : clock, rising edge
//   rf_reset     : asynchronous active-high reset
//   rf_wr        : write enable (ignored while clearing)
//   rf_wr_addr   : write address
//   rf_in        : write data
//   rf_rd_addr_a : read address, port A
//   rf_rd_addr_b : read address, port B
//   rf_clear     : bulk-clear request, sampled in IDLE
//   rf_out_a     : registered read data, port A
//   rf_out_b     : registered read data, port B
//   rf_busy      : high while the clear sequence runs
//
//   state | meaning
//   IDLE  | normal operation, external writes accepted, rf_clear sampled
//   CLEAR | one entry per edge reset to RESET_VALUE, external writes dropped
module register_file
  import register_file_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  rf_reset,
  input  logic                  rf_wr,
  input  logic [ADDR_WIDTH-1:0] rf_wr_addr,
  input  logic [DATA_WIDTH-1:0] rf_in,
  input  logic [ADDR_WIDTH-1:0] rf_rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rf_rd_addr_b,
  input  logic                  rf_clear,
  output logic [DATA_WIDTH-1:0] rf_out_a,
  output logic [DATA_WIDTH-1:0] rf_out_b,
  output logic                  rf_busy
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  clear_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, ptr_next;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ext_wr_ok;

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clock or posedge rf_reset) begin
    if (rf_reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The pointer wraps to zero on the same edge that leaves CLEAR, so no
  // extra cycle sits between the last entry and IDLE.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (rf_clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        ptr_next = ptr + ADDR_WIDTH'(1);
        if (ptr == {ADDR_WIDTH{1'b1}}) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

`ifdef RF_ZERO_REG_EN
  assign ext_wr_ok = rf_wr && (rf_wr_addr != '0);
`else
  assign ext_wr_ok = rf_wr;
`endif

  // One write path shared by the external port and the clear engine; the
  // read ports bypass from it, so clear writes are bypassed too.
  always_comb begin
    rf_busy = 1'b0;
    wr_en   = 1'b0;
    wr_addr = rf_wr_addr;
    wr_data = rf_in;
    case (state)
      IDLE: begin
        wr_en = ext_wr_ok;
      end
      CLEAR: begin
        rf_busy = 1'b1;
        wr_en   = 1'b1;
        wr_addr = ptr;
        wr_data = RESET_VALUE;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rf_reset) begin
    if (rf_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= RESET_VALUE;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_port_a (
    .clock    (clock),
    .rf_reset (rf_reset),
    .word     (mem[rf_rd_addr_a]),
    .rd_addr  (rf_rd_addr_a),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rf_out_a)
  );

  register_file_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_port_b (
    .clock    (clock),
    .rf_reset (rf_reset),
    .word     (mem[rf_rd_addr_b]),
    .rd_addr  (rf_rd_addr_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rf_out_b)
  );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Directed bench for register_file with a behavioural reference model.
//   Build with RF_ZERO_REG_EN defined to exercise the hardwired entry 0.
module tb_register_file;
  import register_file_pkg::*;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic  clock;
  logic  rf_reset;
  logic  rf_wr;
  addr_t rf_wr_addr;
  data_t rf_in;
  addr_t rf_rd_addr_a;
  addr_t rf_rd_addr_b;
  logic  rf_clear;
  data_t rf_out_a;
  data_t rf_out_b;
  logic  rf_busy;

  int checks = 0;
  int errors = 0;

  register_file #(
    .DATA_WIDTH  (DEFAULT_DATA_WIDTH),
    .ADDR_WIDTH  (DEFAULT_ADDR_WIDTH),
    .RESET_VALUE ('0)
  ) dut (
    .clock        (clock),
    .rf_reset     (rf_reset),
    .rf_wr        (rf_wr),
    .rf_wr_addr   (rf_wr_addr),
    .rf_in        (rf_in),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .rf_clear     (rf_clear),
    .rf_out_a     (rf_out_a),
    .rf_out_b     (rf_out_b),
    .rf_busy      (rf_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: storage as an array, clear as "entries remaining".
  data_t m_mem [DEPTH];
  data_t m_a, m_b;
  int    m_left;
  bit    m_we;
  int    m_wa;
  data_t m_wd;

  always @(posedge clock or posedge rf_reset) begin
    if (rf_reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_a    = '0;
      m_b    = '0;
      m_left = 0;
    end else begin
      if (m_left > 0) begin
        m_we = 1'b1;
        m_wa = DEPTH - m_left;
        m_wd = '0;
        m_left--;
      end else begin
        m_we = rf_wr && !(ZERO && rf_wr_addr == 0);
        m_wa = int'(rf_wr_addr);
        m_wd = rf_in;
        if (rf_clear) m_left = DEPTH;
      end
      m_a = (m_we && m_wa == int'(rf_rd_addr_a)) ? m_wd : m_mem[rf_rd_addr_a];
      m_b = (m_we && m_wa == int'(rf_rd_addr_b)) ? m_wd : m_mem[rf_rd_addr_b];
      if (m_we) m_mem[m_wa] = m_wd;
    end
  end

  always @(posedge clock) begin
    #1;
    check("model_out_a", rf_out_a, m_a);
    check("model_out_b", rf_out_b, m_b);
    check("model_busy", rf_busy, m_left > 0);
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic write(input addr_t a, input data_t d);
    rf_wr      = 1'b1;
    rf_wr_addr = a;
    rf_in      = d;
    step();
    rf_wr      = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rf_rd_addr_a = addr_t'(i);
      rf_rd_addr_b = addr_t'(DEPTH - 1 - i);
      step();
      check({tag, "_a"}, rf_out_a, 0);
      check({tag, "_b"}, rf_out_b, 0);
    end
  endtask

  int busy_cycles;
  int lows;

  initial begin
    rf_reset     = 1'b1;
    rf_wr        = 1'b0;
    rf_wr_addr   = '0;
    rf_in        = '0;
    rf_rd_addr_a = '0;
    rf_rd_addr_b = '0;
    rf_clear     = 1'b0;
    repeat (3) step();
    check("reset_busy", rf_busy, 0);
    check("reset_out_a", rf_out_a, 0);
    rf_reset = 1'b0;

    read_all_zero("reset_read");
    check("idle_busy", rf_busy, 0);

    write(3'd3, 8'hA5);
    rf_rd_addr_a = 3'd3;
    rf_rd_addr_b = 3'd3;
    step();
    check("read_a5_a", rf_out_a, 8'hA5);
    check("read_a5_b", rf_out_b, 8'hA5);

    write(3'd2, 8'h11);
    rf_rd_addr_a = 3'd5;
    rf_rd_addr_b = 3'd2;
    write(3'd5, 8'h3C);
    check("bypass_a", rf_out_a, 8'h3C);
    check("plain_b", rf_out_b, 8'h11);

    // Bulk clear over a full file, with an external write attempted inside.
    for (int i = 0; i < DEPTH; i++) write(addr_t'(i), data_t'(8'h10 + i));
    rf_rd_addr_a = 3'd7;
    rf_rd_addr_b = 3'd6;
    rf_clear = 1'b1;
    step();
    rf_clear = 1'b0;
    check("clear_busy_start", rf_busy, 1);
    check("clear_read7_pre", rf_out_a, 8'h17);
    rf_wr      = 1'b1;
    rf_wr_addr = 3'd7;
    rf_in      = 8'hFF;
    busy_cycles = 1;
    for (int n = 0; n < 20 && rf_busy; n++) begin
      step();
      if (rf_busy) busy_cycles++;
    end
    rf_wr = 1'b0;
    check("clear_busy_len", busy_cycles, DEPTH);
    check("clear_read7_post", rf_out_a, 0);
    read_all_zero("after_clear");

    // Reset in the middle of a clear.
    write(3'd4, 8'h55);
    rf_clear = 1'b1;
    step();
    rf_clear = 1'b0;
    step();
    step();
    check("midclear_busy", rf_busy, 1);
    #2;
    rf_reset = 1'b1;
    #1;
    check("abort_busy", rf_busy, 0);
    check("abort_out_a", rf_out_a, 0);
    step();
    rf_reset = 1'b0;
    read_all_zero("after_abort");
    rf_rd_addr_a = 3'd6;
    write(3'd6, 8'h42);
    check("post_abort_write", rf_out_a, 8'h42);
    step();
    check("post_abort_read", rf_out_a, 8'h42);

    // Clear held high: two sequences separated by one idle cycle.
    lows = 0;
    rf_clear = 1'b1;
    for (int s = 0; s < 2 * DEPTH + 1; s++) begin
      step();
      if (!rf_busy) lows++;
    end
    rf_clear = 1'b0;
    check("b2b_idle_gap", lows, 1);
    check("b2b_second_busy", rf_busy, 1);
    step();
    check("b2b_exit", rf_busy, 0);

    // Entry 0: hardwired when RF_ZERO_REG_EN, ordinary otherwise.
    rf_rd_addr_a = 3'd0;
    rf_rd_addr_b = 3'd0;
    write(3'd0, 8'h99);
    check("zero_bypass", rf_out_a, ZERO ? 8'h00 : 8'h99);
    step();
    check("zero_read_a", rf_out_a, ZERO ? 8'h00 : 8'h99);
    check("zero_read_b", rf_out_b, ZERO ? 8'h00 : 8'h99);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
